// File: rtl/dmem_msg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_msg_arbiter
// Brief    : Shares the dmem port between the processor and the GPIO receive
//            path; copies a completed 128-bit message into a dmem mailbox
//            using idle processor cycles, stealing one cycle on starvation.
//            Optional macro DMEM_ARB_FLAG_EN adds a trailing "ready" flag write.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_msg_arbiter #(
    parameter logic [11:0] BASE_ADDR    = 12'hF00,
    parameter int          WORDS        = 4,
    parameter int          STARVE_LIMIT = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [11:0]  cpu_addr,
    input  logic [31:0]  cpu_data,
    input  logic         cpu_wren,
    input  logic         cpu_req,
    input  logic         msg_valid,
    input  logic [127:0] msg_in,
    output logic [11:0]  mem_addr,
    output logic [31:0]  mem_data,
    output logic         mem_wren,
    output logic         cpu_stall,
    output logic         busy,
    output logic         msg_done,
    output logic         overflow
);

    localparam int              c_IW       = $clog2(WORDS);
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(WORDS - 1);
    localparam logic [3:0]      c_LIMIT    = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef DMEM_ARB_FLAG_EN
        FLAG = 2'd2,
`endif
        COPY = 2'd1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [c_IW-1:0]            r_idx;
    logic [3:0]                 r_starve;
    logic [WORDS-1:0][31:0]     r_buf;
    logic                       r_done;
    logic                       r_ovf;

    logic                       w_active;
    logic                       w_force;
    logic                       w_grant;
    logic                       w_final;
    logic [c_IW-1:0]            w_sel;
    logic [11:0]                w_dma_addr;
    logic [31:0]                w_dma_data;

    // Word 0 is the top of the message, which lands in the highest buffer slot.
    assign w_sel    = c_LAST_IDX - r_idx;
    assign w_active = (r_state != IDLE) && !reset;
    assign w_force  = (r_starve == c_LIMIT);
    assign w_grant  = w_active && (!cpu_req || w_force);

    always_comb begin
        w_dma_addr = BASE_ADDR + 12'(r_idx);
        w_dma_data = r_buf[w_sel];
`ifdef DMEM_ARB_FLAG_EN
        if (r_state == FLAG) begin
            w_dma_addr = BASE_ADDR + 12'(WORDS);
            w_dma_data = 32'h0000_0001;
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_final     = 1'b0;
        case (r_state)
            IDLE: begin
                if (msg_valid) w_state_nxt = COPY;
            end
            COPY: begin
                if (w_grant && (r_idx == c_LAST_IDX)) begin
`ifdef DMEM_ARB_FLAG_EN
                    w_state_nxt = FLAG;
`else
                    w_state_nxt = IDLE;
                    w_final     = 1'b1;
`endif
                end
            end
`ifdef DMEM_ARB_FLAG_EN
            FLAG: begin
                if (w_grant) begin
                    w_state_nxt = IDLE;
                    w_final     = 1'b1;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_starve <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_final;
            if (msg_valid && (r_state != IDLE)) r_ovf <= 1'b1;
            if (r_state == IDLE) begin
                r_idx    <= '0;
                r_starve <= '0;
            end else if (w_grant) begin
                r_idx    <= r_idx + 1'b1;
                r_starve <= '0;
            end else if (!w_force) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end

    // Buffer contents after a reset are irrelevant, so it carries no reset.
    always_ff @(posedge clock) begin
        if (msg_valid && (r_state == IDLE)) r_buf <= msg_in;
    end

    assign mem_addr  = w_grant ? w_dma_addr : cpu_addr;
    assign mem_data  = w_grant ? w_dma_data : cpu_data;
    assign mem_wren  = w_grant ? 1'b1       : cpu_wren;
    assign cpu_stall = w_active && w_force && cpu_req;
    assign busy      = (r_state != IDLE);
    assign msg_done  = r_done;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dmem_msg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_msg_arbiter
// Brief    : Randomized bench for dmem_msg_arbiter with a queue-based model of
//            pending mailbox writes; honours DMEM_ARB_FLAG_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_msg_arbiter;

    localparam logic [11:0] c_BASE  = 12'hF00;
    localparam int          c_WORDS = 4;
    localparam int          c_LIMIT = 8;
`ifdef DMEM_ARB_FLAG_EN
    localparam int          c_LEN   = c_WORDS + 1;
`else
    localparam int          c_LEN   = c_WORDS;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic [11:0]  cpu_addr;
    logic [31:0]  cpu_data;
    logic         cpu_wren;
    logic         cpu_req;
    logic         msg_valid;
    logic [127:0] msg_in;
    logic [11:0]  mem_addr;
    logic [31:0]  mem_data;
    logic         mem_wren;
    logic         cpu_stall;
    logic         busy;
    logic         msg_done;
    logic         overflow;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Model: outstanding mailbox writes as {addr, data}, oldest first.
    logic [43:0] wq[$];
    int          m_starve = 0;
    bit          m_done   = 1'b0;
    bit          m_ovf    = 1'b0;

    dmem_msg_arbiter #(
        .BASE_ADDR   (c_BASE),
        .WORDS       (c_WORDS),
        .STARVE_LIMIT(c_LIMIT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .cpu_wren (cpu_wren),
        .cpu_req  (cpu_req),
        .msg_valid(msg_valid),
        .msg_in   (msg_in),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_wren (mem_wren),
        .cpu_stall(cpu_stall),
        .busy     (busy),
        .msg_done (msg_done),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: checks the current cycle, then advances the model
    // with the inputs that the coming rising edge will sample.
    always @(negedge clock) begin
        if (mon_en) begin
            bit          pend;
            bit          frc;
            bit          gnt;
            logic [43:0] w;
            pend = (wq.size() != 0);
            frc  = pend && (m_starve == c_LIMIT);
            gnt  = !reset && pend && (!cpu_req || frc);
            chk("busy", 64'(busy), 64'(pend));
            chk("msg_done", 64'(msg_done), 64'(m_done));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("cpu_stall", 64'(cpu_stall), 64'(!reset && frc && cpu_req));
            if (gnt) begin
                w = wq[0];
                chk("dma_addr", 64'(mem_addr), 64'(w[43:32]));
                chk("dma_data", 64'(mem_data), 64'(w[31:0]));
                chk("dma_wren", 64'(mem_wren), 64'(1));
            end else begin
                chk("mirror_addr", 64'(mem_addr), 64'(cpu_addr));
                chk("mirror_data", 64'(mem_data), 64'(cpu_data));
                chk("mirror_wren", 64'(mem_wren), 64'(cpu_wren));
            end
            if (reset) begin
                wq.delete();
                m_starve = 0;
                m_done   = 1'b0;
                m_ovf    = 1'b0;
            end else begin
                m_done = 1'b0;
                if (gnt) begin
                    void'(wq.pop_front());
                    m_starve = 0;
                    if (wq.size() == 0) m_done = 1'b1;
                end else if (pend) begin
                    m_starve = (m_starve >= c_LIMIT) ? c_LIMIT : m_starve + 1;
                end
                if (msg_valid) begin
                    if (pend) begin
                        m_ovf = 1'b1;
                    end else begin
                        for (int i = 0; i < c_WORDS; i++)
                            wq.push_back({c_BASE + 12'(i), msg_in[127 - 32*i -: 32]});
`ifdef DMEM_ARB_FLAG_EN
                        wq.push_back({c_BASE + 12'(c_WORDS), 32'h0000_0001});
`endif
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_drive(input bit req);
        cpu_req  = req;
        cpu_addr = 12'($urandom);
        cpu_data = $urandom;
        cpu_wren = req ? 1'($urandom) : 1'b0;
    endtask

    task automatic send(input logic [127:0] m);
        msg_valid = 1'b1;
        msg_in    = m;
        cyc();
        msg_valid = 1'b0;
        msg_in    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_drive(1'b0);
            cyc();
        end
    endtask

    initial begin
        reset     = 1'b1;
        msg_valid = 1'b0;
        msg_in    = '0;
        cpu_drive(1'b0);
        cyc();
        mon_en = 1'b1;
        cyc();
        reset = 1'b0;
        idle(2);

        // Processor idle: full copy with nominal latency.
        send(128'h00112233_44556677_8899AABB_CCDDEEFF);
        idle(c_LEN + 3);

        // Processor busy for three cycles starting at the second write.
        send(128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        cpu_drive(1'b0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            cpu_drive(1'b1);
            cyc();
        end
        idle(c_LEN + 3);

        // Processor never idle: every write is a forced stolen cycle.
        send(128'h11111111_22222222_33333333_44444444);
        for (int i = 0; i < (c_LIMIT + 1) * c_LEN + 4; i++) begin
            cpu_drive(1'b1);
            cyc();
        end
        idle(3);

        // Second message while busy is dropped and sets overflow.
        send(128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0);
        cpu_drive(1'b0);
        cyc();
        send(128'h99999999_88888888_77777777_66666666);
        idle(c_LEN + 3);

        // Reset in the middle of a copy.
        send(128'h12345678_9ABCDEF0_0FEDCBA9_87654321);
        idle(2);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        idle(c_LEN + 3);

        // New message accepted in the msg_done cycle.
        send(128'hCAFEBABE_FEEDFACE_BAADF00D_0DDBA11E);
        idle(c_LEN);
        send(128'h01010101_02020202_03030303_04040404);
        idle(c_LEN + 3);

        // Random traffic with varying processor load and occasional reset.
        for (int blk = 0; blk < 8; blk++) begin
            int load;
            load = $urandom_range(0, 4);
            for (int i = 0; i < 300; i++) begin
                cpu_drive(1'($urandom_range(0, 4) < load));
                msg_valid = ($urandom_range(0, 24) == 0);
                msg_in    = {$urandom, $urandom, $urandom, $urandom};
                reset     = ($urandom_range(0, 399) == 0);
                cyc();
            end
            msg_valid = 1'b0;
            reset     = 1'b0;
        end

        idle((c_LIMIT + 1) * c_LEN + 4);
        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
